// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus for cla_pipe_adder.
// The producer drives a, b, cin and sub, qualified by in_valid/in_ready.
// The consumer receives sum and the flags, qualified by out_valid/out_ready.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 36
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             gg;
    logic             pg;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, gg, pg, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, gg, pg, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined two-level carry-lookahead adder/subtractor.
// S1 conditions the operands (y = ~b and c0 = ~cin for subtract) and
// registers the 4-bit group generate/propagate terms.
// S2 folds the groups into supergroups of GPS groups and ripples the
// supergroup carries from c0. It then forms the group and bit carries and
// registers sum, cout and the whole-word G/P.
// Define CLA_PIPE_FLAGS_EN to compute and register ovf/zero. Without it,
// both outputs are tied low.
// The interface instance must use the same WIDTH as this module.
module cla_pipe_adder #(
    parameter int WIDTH = 36,
    parameter int GPS   = 4
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NG  = WIDTH / 4;
    localparam int NSG = (NG + GPS - 1) / GPS;

    genvar gi, gj;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 4");
        end
        if (GPS < 1 || GPS > 4) begin : g_bad_gps
            $error("cla_pipe_adder: GPS must be in 1..4");
        end
    endgenerate

    // Handshake: S2 advances when empty or draining; S1 advances when empty or S2 advances.
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_load;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_load;

    // Operand conditioning and bit/group generate-propagate for S1.
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic             c0_d;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;
    logic [NG-1:0]    grp_g_d;
    logic [NG-1:0]    grp_p_d;

    assign x_d   = bus.a;
    assign y_d   = bus.sub ? ~bus.b : bus.b;
    assign c0_d  = bus.sub ? ~bus.cin : bus.cin;
    assign bit_g = x_d & y_d;
    assign bit_p = x_d | y_d;

    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            assign grp_g_d[gi] = bit_g[4*gi+3]
                               | (bit_p[4*gi+3] & bit_g[4*gi+2])
                               | (bit_p[4*gi+3] & bit_p[4*gi+2] & bit_g[4*gi+1])
                               | (bit_p[4*gi+3] & bit_p[4*gi+2] & bit_p[4*gi+1] & bit_g[4*gi]);
            assign grp_p_d[gi] = &bit_p[4*gi +: 4];
        end
    endgenerate

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             c0_q;
    logic [NG-1:0]    grp_g_q;
    logic [NG-1:0]    grp_p_q;

    // S1 register: capture a beat whenever the stage is free to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            c0_q       <= 1'b0;
            grp_g_q    <= '0;
            grp_p_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                x_q     <= x_d;
                y_q     <= y_d;
                c0_q    <= c0_d;
                grp_g_q <= grp_g_d;
                grp_p_q <= grp_p_d;
            end
        end
    end

    // Second lookahead level: supergroup G/P, then the supergroup, group and bit carries.
    logic [NSG-1:0] sg_g;
    logic [NSG-1:0] sg_p;
    logic [NSG:0]   sg_c;
    logic [NG-1:0]  grp_c;
    logic [WIDTH:0] bc;

    assign sg_c[0] = c0_q;

    generate
        for (gi = 0; gi < NSG; gi++) begin : g_sg
            localparam int LO  = gi * GPS;
            localparam int CNT = ((NG - LO) < GPS) ? (NG - LO) : GPS;
            logic g_v;
            logic p_v;

            // Fold this supergroup's groups (a partial top one uses only its own) into one G/P pair.
            always_comb begin
                g_v = 1'b0;
                p_v = 1'b1;
                for (int k = 0; k < CNT; k++) begin
                    g_v = grp_g_q[LO+k] | (grp_p_q[LO+k] & g_v);
                    p_v = p_v & grp_p_q[LO+k];
                end
            end

            assign sg_g[gi]     = g_v;
            assign sg_p[gi]     = p_v;
            assign sg_c[gi+1]   = g_v | (p_v & sg_c[gi]);
            assign grp_c[LO]    = sg_c[gi];
            for (gj = 1; gj < CNT; gj++) begin : g_gc
                assign grp_c[LO+gj] = grp_g_q[LO+gj-1] | (grp_p_q[LO+gj-1] & grp_c[LO+gj-1]);
            end
        end

        for (gi = 0; gi < NG; gi++) begin : g_bc
            assign bc[4*gi] = grp_c[gi];
            for (gj = 0; gj < 3; gj++) begin : g_bit
                assign bc[4*gi+gj+1] = (x_q[4*gi+gj] & y_q[4*gi+gj])
                                     | ((x_q[4*gi+gj] | y_q[4*gi+gj]) & bc[4*gi+gj]);
            end
        end
    endgenerate

    assign bc[WIDTH] = sg_c[NSG];

    logic wg_d;
    logic wp_d;

    // Whole-word G/P, formed from the supergroup terms without involving c0.
    always_comb begin
        wg_d = 1'b0;
        wp_d = 1'b1;
        for (int s = 0; s < NSG; s++) begin
            wg_d = sg_g[s] | (sg_p[s] & wg_d);
            wp_d = wp_d & sg_p[s];
        end
    end

    logic [WIDTH-1:0] sum_d;
    assign sum_d = x_q ^ y_q ^ bc[WIDTH-1:0];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             gg_q;
    logic             pg_q;

    // S2 output register: take S1's beat when advancing and hold it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            gg_q        <= 1'b0;
            pg_q        <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= bc[WIDTH];
                gg_q   <= wg_d;
                pg_q   <= wp_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.gg        = gg_q;
    assign bus.pg        = pg_q;

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Signed overflow and zero flags, registered alongside sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            ovf_q  <= bc[WIDTH-1] ^ bc[WIDTH];
            zero_q <= ~|sum_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder. A main 36-bit instance (GPS=4)
// runs directed, streaming, stall and reset scenarios. Three more instances
// are swept: 4-bit GPS=1 exhaustively, and 12-bit GPS=2 and 36-bit GPS=3
// with random operands.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [35:0] sum;
        logic        cout;
        logic        gg;
        logic        pg;
        logic        ovf;
        logic        zero;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rx36 = 0, rx4 = 0, rx12 = 0, rx36g = 0;
    res_t q36[$], q4[$], q12[$], q36g[$];

    always @(posedge clk) cyc <= cyc + 1;

    cla_pipe_adder_if #(.WIDTH(36)) bm ();
    cla_pipe_adder_if #(.WIDTH(4))  b4 ();
    cla_pipe_adder_if #(.WIDTH(12)) b12 ();
    cla_pipe_adder_if #(.WIDTH(36)) b36g ();

    cla_pipe_adder #(.WIDTH(36), .GPS(4)) u_main (.clk(clk), .rst_n(rst_n), .bus(bm));
    cla_pipe_adder #(.WIDTH(4),  .GPS(1)) u_w4   (.clk(clk), .rst_n(rst_n), .bus(b4));
    cla_pipe_adder #(.WIDTH(12), .GPS(2)) u_w12  (.clk(clk), .rst_n(rst_n), .bus(b12));
    cla_pipe_adder #(.WIDTH(36), .GPS(3)) u_w36g (.clk(clk), .rst_n(rst_n), .bus(b36g));

    // Behavioural reference for a w-bit word: plain a +/- b +/- cin arithmetic.
    function automatic res_t model(input logic [35:0] a, input logic [35:0] b,
                                   input logic cin, input logic sub, input int w);
        logic [36:0] mask, x, y, full, half;
        logic        c0;
        res_t        r;
        mask   = (37'd1 << w) - 37'd1;
        x      = {1'b0, a} & mask;
        y      = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        c0     = sub ? ~cin : cin;
        full   = x + y + {36'd0, c0};
        half   = x + y;
        r.sum  = full[35:0] & mask[35:0];
        r.cout = full[w];
        r.gg   = half[w];
        r.pg   = ((x | y) & mask) == mask;
        r.ovf  = FLAGS && (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
        r.zero = FLAGS && (r.sum == 36'd0);
        return r;
    endfunction

    task automatic check(input string tag, input res_t obs, input res_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("txn %s sum=%h cout=%b gg=%b pg=%b ovf=%b zero=%b",
                 tag, obs.sum, obs.cout, obs.gg, obs.pg, obs.ovf, obs.zero);
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitors: every handshaked result is popped from its scoreboard.
    always @(negedge clk) begin
        if (rst_n && bm.out_valid && bm.out_ready) begin
            rx36++;
            cmp("main_expected_present", 64'(q36.size() != 0), 64'd1);
            if (q36.size() != 0)
                check("main", {bm.sum, bm.cout, bm.gg, bm.pg, bm.ovf, bm.zero}, q36.pop_front());
        end
        if (rst_n && b4.out_valid && b4.out_ready) begin
            rx4++;
            cmp("w4_expected_present", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0)
                check("w4g1", {32'd0, b4.sum, b4.cout, b4.gg, b4.pg, b4.ovf, b4.zero}, q4.pop_front());
        end
        if (rst_n && b12.out_valid && b12.out_ready) begin
            rx12++;
            cmp("w12_expected_present", 64'(q12.size() != 0), 64'd1);
            if (q12.size() != 0)
                check("w12g2", {24'd0, b12.sum, b12.cout, b12.gg, b12.pg, b12.ovf, b12.zero}, q12.pop_front());
        end
        if (rst_n && b36g.out_valid && b36g.out_ready) begin
            rx36g++;
            cmp("w36g3_expected_present", 64'(q36g.size() != 0), 64'd1);
            if (q36g.size() != 0)
                check("w36g3", {b36g.sum, b36g.cout, b36g.gg, b36g.pg, b36g.ovf, b36g.zero}, q36g.pop_front());
        end
    end

    // Present one beat on the main DUT until accepted (entered and left at posedge+1).
    task automatic send(input logic [35:0] a, input logic [35:0] b,
                        input logic cin, input logic sub, input res_t e);
        bit ok = 1'b0;
        bm.in_valid = 1'b1;
        bm.a = a;
        bm.b = b;
        bm.cin = cin;
        bm.sub = sub;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = bm.in_ready;
            if (ok) q36.push_back(e);
            @(posedge clk);
            #1;
        end
        cmp("send_accepted", 64'(ok), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [35:0] ra, rb;
        logic        rc, rs;
        int          c0cyc, acc, rx_before;
        bit          take;
        res_t        e;

        bm.in_valid = 0; bm.a = '0; bm.b = '0; bm.cin = 0; bm.sub = 0; bm.out_ready = 1;
        b4.in_valid = 0; b4.a = '0; b4.b = '0; b4.cin = 0; b4.sub = 0; b4.out_ready = 1;
        b12.in_valid = 0; b12.a = '0; b12.b = '0; b12.cin = 0; b12.sub = 0; b12.out_ready = 1;
        b36g.in_valid = 0; b36g.a = '0; b36g.b = '0; b36g.cin = 0; b36g.sub = 0; b36g.out_ready = 1;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_out_valid", 64'(bm.out_valid), 64'd0);
        cmp("rst_in_ready", 64'(bm.in_ready), 64'd1);
        check("rst_outputs", {bm.sum, bm.cout, bm.gg, bm.pg, bm.ovf, bm.zero}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed 1 plus latency: the result must appear exactly two edges after acceptance.
        e = '{sum: 36'o400000000000, cout: 1'b0, gg: 1'b0, pg: 1'b0, ovf: FLAGS, zero: 1'b0};
        send(36'o377777777777, 36'd1, 1'b0, 1'b0, e);
        bm.in_valid = 1'b0;
        @(negedge clk);
        cmp("latency_edge1_out_valid", 64'(bm.out_valid), 64'd0);
        @(negedge clk);
        cmp("latency_edge2_out_valid", 64'(bm.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Directed 2..4 and wrap-around, back to back.
        e = '{sum: 36'o777777777777, cout: 1'b1, gg: 1'b1, pg: 1'b1, ovf: 1'b0, zero: 1'b0};
        send(36'o777777777777, 36'o777777777777, 1'b1, 1'b0, e);
        e = '{sum: 36'd0, cout: 1'b1, gg: 1'b0, pg: 1'b1, ovf: 1'b0, zero: FLAGS};
        send(36'd5, 36'd5, 1'b0, 1'b1, e);
        e = '{sum: 36'o777777777777, cout: 1'b0, gg: 1'b0, pg: 1'b1, ovf: 1'b0, zero: 1'b0};
        send(36'd5, 36'd5, 1'b1, 1'b1, e);
        e = '{sum: 36'd0, cout: 1'b1, gg: 1'b1, pg: 1'b1, ovf: 1'b0, zero: FLAGS};
        send(36'o777777777777, 36'd1, 1'b0, 1'b0, e);
        bm.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cmp("directed_drained", 64'(q36.size()), 64'd0);

        // 16 random beats back to back with out_ready=1: one accept per cycle.
        c0cyc = cyc;
        for (int i = 0; i < 16; i++) begin
            ra = {4'($urandom), 32'($urandom)};
            rb = {4'($urandom), 32'($urandom)};
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs, 36));
        end
        cmp("b2b_cycles", 64'(cyc - c0cyc), 64'd16);
        bm.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("b2b_drained", 64'(q36.size()), 64'd0);

        // Stall: out_ready=0 for 5 cycles, offering a new beat after each accept.
        bm.out_ready = 1'b0;
        acc = 0;
        take = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (take) begin
                ra = {4'($urandom), 32'($urandom)};
                rb = {4'($urandom), 32'($urandom)};
                rc = 1'($urandom);
                rs = 1'($urandom);
                bm.in_valid = 1'b1; bm.a = ra; bm.b = rb; bm.cin = rc; bm.sub = rs;
            end
            @(negedge clk);
            take = bm.in_ready;
            if (take) begin
                q36.push_back(model(ra, rb, rc, rs, 36));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bm.in_valid = 1'b0;
        @(negedge clk);
        cmp("stall_accepts", 64'(acc), 64'd2);
        cmp("stall_in_ready", 64'(bm.in_ready), 64'd0);
        cmp("stall_out_valid", 64'(bm.out_valid), 64'd1);
        if (q36.size() != 0) cmp("stall_sum_held", 64'(bm.sum), 64'(q36[0].sum));
        @(posedge clk);
        #1;
        bm.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cmp("stall_drained", 64'(q36.size()), 64'd0);

        // Reset with two beats in flight: they must vanish.
        bm.out_ready = 1'b0;
        send(36'd1, 36'd2, 1'b0, 1'b0, model(36'd1, 36'd2, 1'b0, 1'b0, 36));
        send(36'd3, 36'd4, 1'b0, 1'b0, model(36'd3, 36'd4, 1'b0, 1'b0, 36));
        bm.in_valid = 1'b0;
        @(negedge clk);
        cmp("inflight_in_ready", 64'(bm.in_ready), 64'd0);
        cmp("inflight_out_valid", 64'(bm.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_out_valid", 64'(bm.out_valid), 64'd0);
        q36.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp("post_rst_in_ready", 64'(bm.in_ready), 64'd1);
        bm.out_ready = 1'b1;
        rx_before = rx36;
        repeat (5) @(posedge clk);
        #1;
        cmp("post_rst_no_stale", 64'(rx36 - rx_before), 64'd0);

        // Width/GPS sweep: 4-bit exhaustive, 12/36-bit random, all streaming.
        for (int i = 0; i < 1024; i++) begin
            b4.in_valid = 1'b1;
            b4.a = 4'(i);
            b4.b = 4'(i >> 4);
            b4.cin = 1'(i >> 8);
            b4.sub = 1'(i >> 9);
            b12.in_valid = 1'b1;
            b12.a = 12'($urandom);
            b12.b = (i < 4) ? 12'hfff : 12'($urandom);
            b12.cin = 1'($urandom);
            b12.sub = 1'($urandom);
            b36g.in_valid = 1'b1;
            b36g.a = {4'($urandom), 32'($urandom)};
            b36g.b = {4'($urandom), 32'($urandom)};
            b36g.cin = 1'($urandom);
            b36g.sub = 1'($urandom);
            @(negedge clk);
            if (b4.in_ready)
                q4.push_back(model({32'd0, b4.a}, {32'd0, b4.b}, b4.cin, b4.sub, 4));
            if (b12.in_ready)
                q12.push_back(model({24'd0, b12.a}, {24'd0, b12.b}, b12.cin, b12.sub, 12));
            if (b36g.in_ready)
                q36g.push_back(model(b36g.a, b36g.b, b36g.cin, b36g.sub, 36));
            @(posedge clk);
            #1;
        end
        b4.in_valid = 1'b0;
        b12.in_valid = 1'b0;
        b36g.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cmp("sweep_w4_count", 64'(rx4), 64'd1024);
        cmp("sweep_w12_count", 64'(rx12), 64'd1024);
        cmp("sweep_w36g3_count", 64'(rx36g), 64'd1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
